// File: rtl/dram_lsu_pkg.sv
// Purpose: shared types and constants for the DRAM load/store unit.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package dram_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Loads and stores share funct3 encodings, so store names alias load names.
  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } mem_funct3_e;

  localparam mem_funct3_e F3_SB = F3_LB;
  localparam mem_funct3_e F3_SH = F3_LH;
  localparam mem_funct3_e F3_SW = F3_LW;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  localparam logic [3:0] LSU_WE_ALL = 4'hF;

  // Misalignment or an encoding that names no RV32 load/store.
  function automatic logic lsu_is_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic e;
    e = 1'b0;
    if (we) e = (f3 > 3'd2);
    else    e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if ((f3[1:0] == 2'b01) && off[0]) e = 1'b1;
    if ((f3 == F3_LW) && (off != 2'b00)) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/dram_lsu_byte_lane.sv
// Purpose: lane select + sign/zero extension for loads, lane merge for stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_byte_lane
  import dram_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_mdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // Pick the addressed byte out of the word.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // Load path: extend the selected lane to 32 bits.
  always_comb begin
    o_ldata = '0;
    case (i_funct3)
      F3_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ldata = {{16{w_half[15]}}, w_half};
      F3_LW:   o_ldata = i_word;
      F3_LBU:  o_ldata = {24'h0, w_byte};
      F3_LHU:  o_ldata = {16'h0, w_half};
      default: o_ldata = '0;
    endcase
  end

  // Store path: overlay the right-aligned store data onto the old word.
  always_comb begin
    o_mdata = i_word;
    case (i_funct3)
      F3_SB: begin
        case (i_offset)
          2'd0:    o_mdata[7:0]   = i_wdata[7:0];
          2'd1:    o_mdata[15:8]  = i_wdata[7:0];
          2'd2:    o_mdata[23:16] = i_wdata[7:0];
          default: o_mdata[31:24] = i_wdata[7:0];
        endcase
      end
      F3_SH: begin
        if (i_offset[1]) o_mdata[31:16] = i_wdata[15:0];
        else             o_mdata[15:0]  = i_wdata[15:0];
      end
      F3_SW:   o_mdata = i_wdata;
      default: o_mdata = i_word;
    endcase
  end

endmodule

// File: rtl/dram_lsu.sv
// Purpose: one-at-a-time RV32 load/store unit driving a word-addressed DRAM.
// Latency: rsp_valid at accept+1 (error), +2 (SW), +3 (load), +4 (SB/SH).
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
module dram_lsu
  import dram_lsu_pkg::*;
#(
  parameter int DRAM_AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [DRAM_AW-1:0] dram_a,
  output logic [3:0]         dram_we,
  output logic [31:0]        dram_din,
  input  logic [31:0]        dram_spo
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  lsu_req_t          r_req;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              w_req_err;
  logic [DRAM_AW-1:0] w_idx;
  logic [31:0]       w_ldata;
  logic [31:0]       w_mdata;
  logic              w_unused_addr;

  assign w_req_err     = lsu_is_err(req_we, req_funct3, req_addr[1:0]);
  assign w_idx         = r_req.addr[DRAM_AW+1:2];
  // High address bits are deliberately dropped: the word index wraps.
  assign w_unused_addr = ^r_req.addr[31:DRAM_AW+2];

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  lsu_byte_lane u_lane (
    .i_funct3 (r_req.funct3),
    .i_offset (r_req.addr[1:0]),
    .i_word   (dram_spo),
    .i_wdata  (r_req.wdata),
    .o_ldata  (w_ldata),
    .o_mdata  (w_mdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and DRAM port / handshake outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    dram_a    = '0;
    dram_we   = 4'h0;
    dram_din  = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                           w_next = ST_RESP;
          else if (req_we && (req_funct3 == F3_SW)) w_next = ST_WR;
          else                                     w_next = ST_RD;
        end
      end
      ST_RD: begin
        dram_a = w_idx;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_next = r_req.we ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        dram_a   = w_idx;
        dram_we  = LSU_WE_ALL;
        dram_din = r_word;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, merged write word and response data.
  // rsp_rdata/rsp_err only change when a response is about to be presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req  <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
            // SW writes the store data unchanged; sub-word stores overwrite this in WAIT.
            r_word <= req_wdata;
            if (w_req_err) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (r_req.we) begin
            r_word <= w_mdata;
          end else begin
            r_rdata <= w_ldata;
            r_err   <= 1'b0;
          end
        end
        ST_WR: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_lsu.sv
// Purpose: directed self-checking bench for dram_lsu with a behavioural DRAM.
// Latency: checks response cycle per op class against fixed expectations.
// Backpressure: exercises req_valid held high across busy cycles.
module tb_dram_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] dram_a;
  logic [3:0]  dram_we;
  logic [31:0] dram_din;
  logic [31:0] dram_spo;

  logic [31:0] mem [0:65535];
  int wr_cnt = 0;
  int rsp_cnt = 0;
  int n_assert = 0;
  int n_fail = 0;

  int          wr_before;
  int          rsp_before;
  int          bi;
  int          ng;
  logic        pend;
  logic        b_we   [6];
  logic [2:0]  b_f3   [6];
  logic [31:0] b_addr [6];
  logic [31:0] b_wd   [6];
  logic [31:0] b_exp  [6];
  logic        b_err  [6];
  logic [31:0] got    [6];
  logic        goterr [6];

  dram_lsu #(.DRAM_AW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dram_a     (dram_a),
    .dram_we    (dram_we),
    .dram_din   (dram_din),
    .dram_spo   (dram_spo)
  );

  always #5 clk = ~clk;

  // Behavioural DRAM: whole-word write, one-cycle synchronous read; plus event counters.
  always @(posedge clk) begin
    if (dram_we == 4'hF) mem[dram_a] <= dram_din;
    dram_spo <= mem[dram_a];
    if (dram_we != 4'h0) wr_cnt <= wr_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request: checks ready, DRAM port in cycle 1, response cycle, data and error flag.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [15:0] exp_a1, input logic [3:0] exp_we1);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        chk({tag, "/dram_a@1"}, 32'(dram_a), 32'(exp_a1));
        chk({tag, "/dram_we@1"}, 32'(dram_we), 32'(exp_we1));
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, sampled while reset is still asserted after an edge.
    @(negedge clk);
    @(negedge clk);
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'd0);
    chk("rst/rsp_err", 32'(rsp_err), 32'd0);
    chk("rst/dram_a", 32'(dram_a), 32'd0);
    chk("rst/dram_we", 32'(dram_we), 32'd0);
    chk("rst/dram_din", dram_din, 32'd0);
    rst = 1'b0;

    do_req("sw1000", 1'b1, 3'd2, 32'h1000, 32'hDEADBEEF, 2, 32'h0, 1'b0, 16'h0400, 4'hF);
    chk("mem_after_sw", mem[16'h0400], 32'hDEADBEEF);
    do_req("lw1000", 1'b0, 3'd2, 32'h1000, 32'h0, 3, 32'hDEADBEEF, 1'b0, 16'h0400, 4'h0);

    do_req("sb1003", 1'b1, 3'd0, 32'h1003, 32'h000000AA, 4, 32'h0, 1'b0, 16'h0400, 4'h0);
    chk("mem_after_sb", mem[16'h0400], 32'hAAADBEEF);
    do_req("lb1003", 1'b0, 3'd0, 32'h1003, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 16'h0400, 4'h0);
    do_req("lbu1003", 1'b0, 3'd4, 32'h1003, 32'h0, 3, 32'h000000AA, 1'b0, 16'h0400, 4'h0);

    do_req("sw_11223344", 1'b1, 3'd2, 32'h1000, 32'h11223344, 2, 32'h0, 1'b0, 16'h0400, 4'hF);
    do_req("sh1002", 1'b1, 3'd1, 32'h1002, 32'h00001234, 4, 32'h0, 1'b0, 16'h0400, 4'h0);
    chk("mem_after_sh", mem[16'h0400], 32'h12343344);
    do_req("lh1002", 1'b0, 3'd1, 32'h1002, 32'h0, 3, 32'h00001234, 1'b0, 16'h0400, 4'h0);

    do_req("sw_f00d", 1'b1, 3'd2, 32'h1000, 32'h0000F00D, 2, 32'h0, 1'b0, 16'h0400, 4'hF);
    do_req("lhu1000", 1'b0, 3'd5, 32'h1000, 32'h0, 3, 32'h0000F00D, 1'b0, 16'h0400, 4'h0);
    do_req("lh1000", 1'b0, 3'd1, 32'h1000, 32'h0, 3, 32'hFFFFF00D, 1'b0, 16'h0400, 4'h0);

    // Error cases: response in cycle 1, no DRAM write, memory untouched.
    wr_before = wr_cnt;
    do_req("err_lw1001", 1'b0, 3'd2, 32'h1001, 32'h0, 1, 32'h0, 1'b1, 16'h0000, 4'h0);
    do_req("err_sh1001", 1'b1, 3'd1, 32'h1001, 32'h0000BEEF, 1, 32'h0, 1'b1, 16'h0000, 4'h0);
    do_req("err_ld_f3_3", 1'b0, 3'd3, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 16'h0000, 4'h0);
    do_req("err_st_f3_4", 1'b1, 3'd4, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 16'h0000, 4'h0);
    @(negedge clk);
    chk("err/no_writes", 32'(wr_cnt - wr_before), 32'd0);
    chk("err/mem_unchanged", mem[16'h0400], 32'h0000F00D);

    do_req("sw0000", 1'b1, 3'd2, 32'h0000, 32'hCAFEF00D, 2, 32'h0, 1'b0, 16'h0000, 4'hF);

    // Reset while an SB sits in WAIT: no response, no write afterwards.
    @(negedge clk);
    wr_before  = wr_cnt;
    rsp_before = rsp_cnt;
    chk("rstmid/ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h1000;
    req_wdata  = 32'h00000055;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid/ready_after", 32'(req_ready), 32'd1);
    chk("rstmid/rsp_valid_after", 32'(rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    chk("rstmid/no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
    chk("rstmid/no_write", 32'(wr_cnt - wr_before), 32'd0);
    chk("rstmid/mem_unchanged", mem[16'h0400], 32'h0000F00D);

    do_req("lw0000", 1'b0, 3'd2, 32'h0000, 32'h0, 3, 32'hCAFEF00D, 1'b0, 16'h0000, 4'h0);
    // Bits above the word index are ignored.
    do_req("lw_wrap", 1'b0, 3'd2, 32'h00041000, 32'h0, 3, 32'h0000F00D, 1'b0, 16'h0400, 4'h0);

    // Back-to-back with req_valid held high.
    b_we[0] = 1'b1; b_f3[0] = 3'd2; b_addr[0] = 32'h2000; b_wd[0] = 32'h01020304; b_exp[0] = 32'h0;        b_err[0] = 1'b0;
    b_we[1] = 1'b0; b_f3[1] = 3'd2; b_addr[1] = 32'h2000; b_wd[1] = 32'h0;        b_exp[1] = 32'h01020304; b_err[1] = 1'b0;
    b_we[2] = 1'b1; b_f3[2] = 3'd0; b_addr[2] = 32'h2001; b_wd[2] = 32'h000000FF; b_exp[2] = 32'h0;        b_err[2] = 1'b0;
    b_we[3] = 1'b0; b_f3[3] = 3'd4; b_addr[3] = 32'h2001; b_wd[3] = 32'h0;        b_exp[3] = 32'h000000FF; b_err[3] = 1'b0;
    b_we[4] = 1'b0; b_f3[4] = 3'd2; b_addr[4] = 32'h2000; b_wd[4] = 32'h0;        b_exp[4] = 32'h0102FF04; b_err[4] = 1'b0;
    b_we[5] = 1'b0; b_f3[5] = 3'd1; b_addr[5] = 32'h2003; b_wd[5] = 32'h0;        b_exp[5] = 32'h0;        b_err[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      got[i]    = 32'hXXXXXXXX;
      goterr[i] = 1'bx;
    end
    @(negedge clk);
    rsp_before = rsp_cnt;
    bi = 0;
    ng = 0;
    req_valid  = 1'b1;
    req_we     = b_we[0];
    req_funct3 = b_f3[0];
    req_addr   = b_addr[0];
    req_wdata  = b_wd[0];
    pend = req_valid && req_ready;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (ng < 6) begin
          got[ng]    = rsp_rdata;
          goterr[ng] = rsp_err;
        end
        ng++;
      end
      if (pend) begin
        bi++;
        if (bi < 6) begin
          req_we     = b_we[bi];
          req_funct3 = b_f3[bi];
          req_addr   = b_addr[bi];
          req_wdata  = b_wd[bi];
        end else begin
          req_valid = 1'b0;
        end
      end
      pend = req_valid && req_ready;
      if ((bi >= 6) && (ng >= 6)) break;
    end
    repeat (6) @(negedge clk);
    chk("b2b/accepted", 32'(bi), 32'd6);
    chk("b2b/responses", 32'(rsp_cnt - rsp_before), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b/rdata[%0d]", i), got[i], b_exp[i]);
      chk($sformatf("b2b/err[%0d]", i), 32'(goterr[i]), 32'(b_err[i]));
    end
    chk("b2b/mem2000", mem[16'h0800], 32'h0102FF04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_lsu.md
# dram_lsu

Load/store unit between the core's memory stage and the `DRAM` data memory.
- Accepts one RV32 load or store at a time over a valid/ready handshake and drives the DRAM's word-addressed port.
- Handles byte and halfword lane select and sign/zero extension on loads.
- The DRAM applies `we` as a whole-word write enable, so sub-word stores are done as read-modify-write.
- Returns one response pulse per request, carrying load data or an error flag.

## Interface
- `DRAM_AW`, 16, DRAM word-address width; word index = `req_addr[DRAM_AW+1:2]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; request accepted on `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 funct3:
  - loads: LB=0, LH=1, LW=2, LBU=4, LHU=5;
  - stores: SB=0, SH=1, SW=2.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors; holds until the next response.
- `rsp_err`  out  1  misaligned or illegal funct3; valid with `rsp_valid`.
- `dram_a`  out  DRAM_AW  word address.
- `dram_we`  out  4  4'hF on a write cycle, else 4'h0.
- `dram_din`  out  32  write data.
- `dram_spo`  in  32  synchronous read data: address held in cycle N gives data in cycle N+1.

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE: on accept, latch op, address, data and lane offset `addr[1:0]`.
  - Error → RESP with err=1, no DRAM access.
  - SW → WR.
  - Otherwise → RD.
- Error conditions:
  - half op with `addr[0]`=1;
  - word op with `addr[1:0]`≠0;
  - load funct3 ∈ {3,6,7};
  - store funct3 > 2.
- RD: `dram_a` = latched word index, `dram_we`=0 → WAIT.
- WAIT: `dram_spo` is valid in this state.
  - Load: register the extracted lane (LB/LH sign-extend, LBU/LHU zero-extend) into `rsp_rdata` → RESP.
  - SB/SH: register `spo` with the selected lane(s) replaced by `req_wdata` → WR.
- WR: `dram_a` = latched index, `dram_we`=4'hF, `dram_din` = merged word (SW: `req_wdata` unchanged) → RESP.
- RESP: `rsp_valid`=1 → IDLE.
- Outside RD/WR: `dram_a`=0, `dram_we`=0, `dram_din`=0.
- Address bits above `DRAM_AW+1` are ignored; word index wraps modulo 2^DRAM_AW.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1 (reset cycle included as IDLE after edge), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0;
  - `dram_a`=0, `dram_we`=0, `dram_din`=0.
- Latency, counted from the accept edge (the accept cycle is cycle 0; `rsp_valid` is high in the cycle listed):
  - error: cycle 1;
  - SW: cycle 2;
  - load: cycle 3;
  - SB/SH: cycle 4.
- Back-to-back: `req_ready` rises the cycle after RESP, so the minimum request spacing is latency+1.
- `req_*` is ignored while not in IDLE; inputs need not be held after accept.
- Reset mid-operation:
  - next state is IDLE and no response is produced;
  - a WR-cycle write coincident with the reset edge still lands in the DRAM, since the DRAM has no reset;
  - no DRAM write is issued in any cycle after reset.
- SB/SH read-modify-write is not atomic with respect to other DRAM masters. This unit is the sole master.

## Structure
- `dram_lsu_pkg` holds:
  - `lsu_state_e`;
  - `mem_funct3_e` (LB..LHU, SB..SW);
  - `lsu_req_t` struct (we, funct3, addr, wdata);
  - constant `LSU_WE_ALL = 4'hF`.
- One combinational sub-module `lsu_byte_lane`:
  - inputs: funct3, offset, word, wdata;
  - outputs: extended load data, merged store word.
- FSM and registers stay in `dram_lsu`.

## Test plan
- SW 0x1000 ← 0xDEADBEEF, then LW 0x1000 → `dram_a`=0x0400 with we=4'hF in cycle 1; load `rsp_rdata`=0xDEADBEEF at cycle 3, err=0.
- SB 0x1003 ← 0x000000AA over 0xDEADBEEF → read then write of 0xAAADBEEF; LB 0x1003 → 0xFFFFFFAA; LBU 0x1003 → 0x000000AA.
- SH 0x1002 ← 0x1234 over 0x11223344 → 0x12343344; LH 0x1002 → 0x00001234; LHU 0x1000 with word 0x0000F00D → 0x0000F00D; LH same → 0xFFFFF00D.
- LW 0x1001, SH 0x1001, load funct3=3 → `rsp_err`=1 at cycle 1, `rsp_rdata`=0, `dram_we` never asserted, memory unchanged.
- `rst` asserted during WAIT of an SB → no `rsp_valid`, no write; `req_ready`=1 the cycle after; a new LW to 0x0000 completes normally at cycle 3.
- Back-to-back requests with `req_valid` held high → each accepted only in IDLE, responses in order, no request dropped or duplicated.
